// File: rtl/id_stage_pkg.sv
// Shared decode constants and types for the instruction-decode stage.
package id_stage_pkg;

    localparam logic [5:0]  OP_RTYPE  = 6'h00;
    localparam logic [5:0]  OP_J      = 6'h02;
    localparam logic [5:0]  OP_BEQ    = 6'h04;
    localparam logic [5:0]  FN_JR     = 6'h08;
    localparam logic [31:0] NOP       = 32'h0;
    localparam logic [31:0] ZERO_WORD = 32'h0;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_JUMP = 2'b01,
        PC_BEQ  = 2'b10,
        PC_JR   = 2'b11
    } pc_src_e;

    typedef struct packed {
        logic is_beq;
        logic is_j;
        logic is_jr;
    } ctl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: r0 hard-wired to zero, write-through bypass on both read ports.
module regfile
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] mem [32];
    logic        wr_live;

    assign wr_live = we && !reset && (waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= ZERO_WORD;
        end else if (wr_live) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-cycle write-back is forwarded so decode never sees a stale value.
    assign rd1 = (ra1 == 5'd0) ? ZERO_WORD : (wr_live && waddr == ra1) ? wdata : mem[ra1];
    assign rd2 = (ra2 == 5'd0) ? ZERO_WORD : (wr_live && waddr == ra2) ? wdata : mem[ra2];

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, branch/jump resolution, load-use and branch-operand hazard stall.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_if,
    input  logic [31:0] pc_4_if,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dst,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dst,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [31:0] beq,
    output logic [31:0] jr,
    output logic [3:0]  pc_4_id,
    output logic [27:0] offset28,
    output logic        id_valid,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] imm_ext,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    logic [31:0] instr_id, pc4_id;
    logic        valid_id;
    ctl_t        ctl;
    pc_src_e     sel;
    logic        live, stall, ld_hit, ex_hit, mem_hit;

    assign opcode   = instr_id[31:26];
    assign rs       = instr_id[25:21];
    assign rt       = instr_id[20:16];
    assign rd       = instr_id[15:11];
    assign funct    = instr_id[5:0];
    assign imm_ext  = sext16(instr_id[15:0]);
    assign offset28 = {instr_id[25:0], 2'b00};
    assign pc_4_id  = pc4_id[31:28];
    assign beq      = pc4_id + (imm_ext << 2);
    assign jr       = rs_data;

    assign ctl.is_beq = (opcode == OP_BEQ);
    assign ctl.is_j   = (opcode == OP_J);
    assign ctl.is_jr  = (opcode == OP_RTYPE) && (funct == FN_JR);

    regfile u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (wb_we),
        .waddr (wb_addr),
        .wdata (wb_data),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_data),
        .rd2   (rt_data)
    );

    assign live = valid_id && !reset;

    // Branches resolve here, so their operands must not be in flight in EX or a load in MEM.
    assign ld_hit  = ex_mem_read && (ex_dst != 5'd0) && (ex_dst == rs || ex_dst == rt);
    assign ex_hit  = ex_reg_write && (ex_dst != 5'd0) && (ex_dst == rs || (ctl.is_beq && ex_dst == rt));
    assign mem_hit = mem_mem_read && (mem_dst != 5'd0) && (mem_dst == rs || (ctl.is_beq && mem_dst == rt));
    assign stall   = live && (ld_hit || ((ctl.is_beq || ctl.is_jr) && (ex_hit || mem_hit)));

    always_comb begin
        sel = PC_SEQ;
        if (live && !stall) begin
            if (ctl.is_j)                               sel = PC_JUMP;
            else if (ctl.is_jr)                         sel = PC_JR;
            else if (ctl.is_beq && rs_data == rt_data)  sel = PC_BEQ;
        end
    end

    assign pc_src   = sel;
    assign pc_write = !stall;
    assign id_valid = live && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_id <= NOP;
            pc4_id   <= ZERO_WORD;
            valid_id <= 1'b0;
        end else if (!stall) begin
            if (sel != PC_SEQ) begin
                instr_id <= NOP;
                pc4_id   <= ZERO_WORD;
                valid_id <= 1'b0;
            end else begin
                instr_id <= instr_if;
                pc4_id   <= pc_4_if;
                valid_id <= 1'b1;
            end
        end
    end

endmodule
